// File: rtl/rom_access_arbiter_if.sv
// Requester-side bus of the ROM access arbiter: request fields in,
// grant / burst status / tagged read data out.
interface rom_access_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
) ();
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [N_REQ-1:0]        gnt;
  logic                    busy;
  logic [DATA_W-1:0]       rd_data;
  logic [N_REQ-1:0]        rd_valid;
  logic                    rd_last;

  // Client side: drives requests, observes grant and returned data.
  modport master (
    output req, req_addr, req_len,
    input  gnt, busy, rd_data, rd_valid, rd_last
  );

  // Arbiter side.
  modport slave (
    input  req, req_addr, req_len,
    output gnt, busy, rd_data, rd_valid, rd_last
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter and burst sequencer in front of a combinational
// single-port ROM. One requester owns the ROM per burst; each burst word is
// read through a registered address and returned as registered data tagged
// one-hot with the owner.
module rom_access_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  rom_access_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [DATA_W-1:0]    rom_data
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic [IDX_W-1:0]    owner_reg, owner_next;
  logic [LEN_W-1:0]    remain_reg, remain_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [N_REQ-1:0]    gnt_reg, gnt_next;
  logic                busy_reg, busy_next;
  logic [DATA_W-1:0]   rd_data_reg, rd_data_next;
  logic [N_REQ-1:0]    rd_valid_reg, rd_valid_next;
  logic                rd_last_reg, rd_last_next;

  // Per-requester views of the packed request fields.
  logic [ADDR_W-1:0]   addr_arr [N_REQ];
  logic [LEN_W-1:0]    len_arr  [N_REQ];

  // Requests rotated so that position 0 is the requester ptr points at;
  // rot_idx maps each rotated position back to a requester number.
  logic [IDX_W-1:0]    rot_idx [N_REQ];
  logic [N_REQ-1:0]    rot_req;

  logic                any_req;
  logic [IDX_W-1:0]    win_off;
  logic [IDX_W-1:0]    win_idx;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      logic [IDX_W:0] rot_sum;

      assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign len_arr[gi]  = bus.req_len[gi*LEN_W +: LEN_W];

      // (ptr + gi) mod N_REQ without a divider: both terms are < N_REQ.
      assign rot_sum     = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
      assign rot_idx[gi] = (rot_sum >= (IDX_W+1)'(N_REQ))
                           ? IDX_W'(rot_sum - (IDX_W+1)'(N_REQ))
                           : rot_sum[IDX_W-1:0];
      assign rot_req[gi] = bus.req[rot_idx[gi]];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the round-robin winner.
  always_comb begin
    any_req = |rot_req;
    win_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        win_off = IDX_W'(k);
      end
    end
  end

  assign win_idx = rot_idx[win_off];

  // Next-state and output decode for the IDLE/BURST sequencer.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    remain_next   = remain_reg;
    addr_next     = addr_reg;
    busy_next     = busy_reg;
    rd_data_next  = rd_data_reg;
    gnt_next      = '0;
    rd_valid_next = '0;
    rd_last_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        // Requests are only evaluated here; anything raised during a burst
        // is picked up on this cycle.
        if (any_req) begin
          owner_next        = win_idx;
          addr_next         = addr_arr[win_idx];
          remain_next       = len_arr[win_idx];
          gnt_next[win_idx] = 1'b1;
          busy_next         = 1'b1;
          state_next        = BURST;
        end
      end

      BURST: begin
        // rom_data is the word at the current registered address.
        rd_data_next            = rom_data;
        rd_valid_next[owner_reg] = 1'b1;
        rd_last_next            = (remain_reg == '0);
        addr_next               = addr_reg + ADDR_W'(1);
        remain_next             = remain_reg - LEN_W'(1);
        if (remain_reg == '0) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          ptr_next   = (owner_reg == IDX_W'(N_REQ - 1))
                       ? '0 : owner_reg + IDX_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      remain_reg   <= '0;
      addr_reg     <= '0;
      gnt_reg      <= '0;
      busy_reg     <= 1'b0;
      rd_data_reg  <= '0;
      rd_valid_reg <= '0;
      rd_last_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      remain_reg   <= remain_next;
      addr_reg     <= addr_next;
      gnt_reg      <= gnt_next;
      busy_reg     <= busy_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
      rd_last_reg  <= rd_last_next;
    end
  end

  assign rom_addr     = addr_reg;
  assign bus.gnt      = gnt_reg;
  assign bus.busy     = busy_reg;
  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_last  = rd_last_reg;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: directed scenarios with literal expectations,
// then randomized requesters, all checked cycle by cycle against a
// burst-schedule model of the arbiter.
module tb_rom_access_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int LW = 3;
  localparam int D  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_access_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  // ROM contents: word[a] = A0 + a.
  assign rom_data = 8'hA0 + {5'd0, rom_addr};

  rom_access_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  // On each grant the whole burst is written into a schedule of future
  // cycles: grant now, busy/address for len+1 cycles, read data one cycle
  // behind each address. Unscheduled cycles mean "quiet".
  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          busy;
    logic          addr_v;
    logic [AW-1:0] addr;
    logic [N-1:0]  rv;
    logic          last;
    logic [DW-1:0] data;
  } slot_t;

  slot_t         sched [D];
  int            cyc = 0;
  int            free_at = 0;
  int            ptr_m = 0;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_data = '0;
  logic [N-1:0]  exp_gnt, exp_rv;
  logic          exp_busy, exp_last;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  bit            model_valid = 1'b0;

  always @(posedge clk) begin : model
    int n, w, words, a;
    slot_t s;
    n   = cyc;
    cyc = cyc + 1;
    if (rst) begin
      for (int j = 0; j < D; j++) sched[j] = '0;
      ptr_m     = 0;
      hold_addr = '0;
      hold_data = '0;
      free_at   = n + 1;
    end else if (n >= free_at && bus.req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && bus.req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      end
      a     = int'(bus.req_addr[w*AW +: AW]);
      words = int'(bus.req_len[w*LW +: LW]) + 1;
      sched[n % D].gnt = N'(1 << w);
      for (int k = 0; k < words; k++) begin
        sched[(n + k) % D].busy      = 1'b1;
        sched[(n + k) % D].addr_v    = 1'b1;
        sched[(n + k) % D].addr      = AW'((a + k) % 8);
        sched[(n + 1 + k) % D].rv    = N'(1 << w);
        sched[(n + 1 + k) % D].data  = DW'(8'hA0 + (a + k) % 8);
        sched[(n + 1 + k) % D].last  = (k == words - 1);
      end
      free_at   = n + words + 1;
      ptr_m     = (w + 1) % N;
      hold_addr = AW'((a + words) % 8);
    end
    s = sched[n % D];
    sched[n % D] = '0;
    exp_gnt  = s.gnt;
    exp_busy = s.busy;
    exp_addr = s.addr_v ? s.addr : hold_addr;
    exp_rv   = s.rv;
    exp_last = s.last;
    if (s.rv != '0) hold_data = s.data;
    exp_data = hold_data;
    model_valid = 1'b1;
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("cyc_gnt",      32'(bus.gnt),      32'(exp_gnt));
      chk("cyc_busy",     32'(bus.busy),     32'(exp_busy));
      chk("cyc_rom_addr", 32'(rom_addr),     32'(exp_addr));
      chk("cyc_rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
      chk("cyc_rd_last",  32'(bus.rd_last),  32'(exp_last));
      chk("cyc_rd_data",  32'(bus.rd_data),  32'(exp_data));
    end
  end

  // One line per granted burst.
  always @(negedge clk) begin
    if (bus.gnt != '0) $display("grant %b start_addr %0d t=%0t", bus.gnt, rom_addr, $time);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int a, input int l);
    bus.req_addr[i*AW +: AW] = AW'(a);
    bus.req_len[i*LW +: LW]  = LW'(l);
    bus.req[i]               = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},      32'(bus.gnt),      0);
    chk({tag, "_busy"},     32'(bus.busy),     0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
    chk({tag, "_rd_last"},  32'(bus.rd_last),  0);
    chk({tag, "_rom_addr"}, 32'(rom_addr),     0);
    chk({tag, "_rd_data"},  32'(bus.rd_data),  0);
  endtask

  int gcnt;
  int gidx [8];
  int gcyc [8];
  int rr_exp [5] = '{0, 1, 2, 3, 0};
  logic [7:0] wrap_exp [4] = '{8'hA6, 8'hA7, 8'hA0, 8'hA1};

  initial begin
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_len  = '0;
    rst          = 1'b1;

    // Reset held two cycles with every requester asserting.
    for (int i = 0; i < N; i++) set_req(i, i, 0);
    repeat (2) begin
      tick();
      chk_all_zero("rst");
    end
    rst = 1'b0;
    tick();
    chk("rst_first_gnt", 32'(bus.gnt), 'b0001);
    bus.req = '0;
    repeat (3) tick();

    // Single word at address 2.
    set_req(0, 2, 0);
    tick();
    chk("single_gnt",  32'(bus.gnt),  'b0001);
    chk("single_addr", 32'(rom_addr), 2);
    chk("single_busy", 32'(bus.busy), 1);
    bus.req[0] = 1'b0;
    tick();
    chk("single_rv",    32'(bus.rd_valid), 'b0001);
    chk("single_data",  32'(bus.rd_data),  'hA2);
    chk("single_last",  32'(bus.rd_last),  1);
    chk("single_busy0", 32'(bus.busy),     0);
    repeat (2) tick();

    // Four-word burst wrapping 7 -> 0.
    set_req(1, 6, 3);
    tick();
    chk("wrap_gnt",  32'(bus.gnt),  'b0010);
    chk("wrap_addr", 32'(rom_addr), 6);
    bus.req[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wrap_rv",   32'(bus.rd_valid), 'b0010);
      chk("wrap_data", 32'(bus.rd_data),  32'(wrap_exp[k]));
      chk("wrap_last", 32'(bus.rd_last),  (k == 3) ? 1 : 0);
    end
    repeat (2) tick();

    // Round-robin from a fresh pointer; requester 0 comes back once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, i + 1, 0);
    gcnt = 0;
    for (int j = 0; j < 8; j++) begin
      gidx[j] = -1;
      gcyc[j] = -100;
    end
    begin
      bit reassert, redone;
      int idx;
      reassert = 1'b0;
      redone   = 1'b0;
      for (int t = 0; t < 14; t++) begin
        tick();
        if (reassert) begin
          bus.req[0] = 1'b1;
          reassert   = 1'b0;
        end
        if (bus.gnt != '0) begin
          idx = 0;
          for (int j = 0; j < N; j++) if (bus.gnt[j]) idx = j;
          if (gcnt < 8) begin
            gidx[gcnt] = idx;
            gcyc[gcnt] = t;
          end
          gcnt++;
          bus.req[idx] = 1'b0;
          if (idx == 0 && !redone) begin
            reassert = 1'b1;
            redone   = 1'b1;
          end
        end
      end
    end
    chk("rr_count", 32'(gcnt), 5);
    for (int j = 0; j < 5; j++) chk("rr_order", 32'(gidx[j]), 32'(rr_exp[j]));
    for (int j = 1; j < 5; j++) chk("rr_spacing", 32'(gcyc[j] - gcyc[j-1]), 2);

    // Reset in the middle of an 8-word burst.
    set_req(2, 0, 7);
    tick();
    chk("mid_gnt", 32'(bus.gnt), 'b0100);
    bus.req[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rv", 32'(bus.rd_valid), 'b0100);
    end
    rst = 1'b1;
    tick();
    chk_all_zero("mid_rst");
    rst = 1'b0;
    set_req(0, 1, 0);
    set_req(3, 5, 1);
    tick();
    chk("post_rst_gnt0", 32'(bus.gnt), 'b0001);
    bus.req[0] = 1'b0;
    repeat (2) tick();
    chk("post_rst_gnt3",  32'(bus.gnt),  'b1000);
    chk("post_rst_addr3", 32'(rom_addr), 5);
    bus.req[3] = 1'b0;
    repeat (4) tick();

    // Requester 1 pulses during requester 0's burst and withdraws.
    set_req(0, 0, 3);
    tick();
    chk("wd_gnt0", 32'(bus.gnt), 'b0001);
    bus.req[0] = 1'b0;
    tick();
    set_req(1, 3, 0);
    tick();
    bus.req[1] = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wd_no_gnt",  32'(bus.gnt),  0);
      chk("wd_no_busy", 32'(bus.busy), 0);
    end

    // Randomized requesters obeying the hold-until-grant protocol.
    for (int t = 0; t < 2500; t++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (bus.req[i]) begin
          if (bus.gnt[i]) bus.req[i] = 1'b0;
          else if ($urandom_range(0, 39) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          set_req(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
      end
    end
    rst     = 1'b0;
    bus.req = '0;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
